// File: rtl/id_forward_scoreboard.sv
// rtl/id_forward_scoreboard.sv - ID-stage operand forwarding and hazard scoreboard
// Optional feature macro: ID_FWD_PERF_CNT_EN (adds o_stall_cnt stall-cycle counter)
module id_forward_scoreboard #(
  parameter  int REG_AW = 5,
  parameter  int DATA_W = 32,
  parameter  int N_RD   = 2,
  parameter  int STAGES = 3,
  parameter  int LAT_W  = 2,
  localparam int SEL_W  = $clog2(STAGES + 1)
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_id_valid,
  input  logic                     i_id_we,
  input  logic [REG_AW-1:0]        i_id_rd,
  input  logic [LAT_W-1:0]         i_id_lat,
  input  logic                     i_flush,
  input  logic [N_RD*REG_AW-1:0]   i_rs,
  input  logic [N_RD*DATA_W-1:0]   i_rf_data,
  input  logic [STAGES*DATA_W-1:0] i_stage_data,
  output logic [N_RD*SEL_W-1:0]    o_fwd_sel,
  output logic [N_RD*DATA_W-1:0]   o_src_data,
  output logic                     o_stall
`ifdef ID_FWD_PERF_CNT_EN
  ,
  output logic [31:0]              o_stall_cnt
`endif
);

  // Scoreboard entries: index 0 is EX, higher indices are older stages.
  logic [STAGES-1:0] valid_q, valid_d;
  logic [REG_AW-1:0] rd_q  [STAGES];
  logic [REG_AW-1:0] rd_d  [STAGES];
  logic [LAT_W-1:0]  rem_q [STAGES];
  logic [LAT_W-1:0]  rem_d [STAGES];

  // Per-port match results.
  logic [N_RD-1:0]   hit_p;
  logic [N_RD-1:0]   pend_p;
  logic [N_RD-1:0]   stall_p;
  logic [SEL_W-1:0]  hit_sel  [N_RD];
  logic [DATA_W-1:0] hit_data [N_RD];
  logic              issue;

  // Resolve each read port against the scoreboard; scanning oldest to youngest lets the youngest match win.
  always_comb begin
    o_fwd_sel  = '0;
    o_src_data = i_rf_data;
    hit_p      = '0;
    pend_p     = '0;
    stall_p    = '0;
    for (int p = 0; p < N_RD; p++) begin
      hit_sel[p]  = '0;
      hit_data[p] = '0;
      for (int k = STAGES - 1; k >= 0; k--) begin
        if (valid_q[k] && (rd_q[k] == i_rs[p*REG_AW +: REG_AW]) &&
            (i_rs[p*REG_AW +: REG_AW] != '0)) begin
          hit_p[p]    = 1'b1;
          pend_p[p]   = (rem_q[k] != '0);
          hit_sel[p]  = SEL_W'(k + 1);
          hit_data[p] = i_stage_data[k*DATA_W +: DATA_W];
        end
      end
      if (hit_p[p] && !pend_p[p]) begin
        o_fwd_sel[p*SEL_W +: SEL_W]   = hit_sel[p];
        o_src_data[p*DATA_W +: DATA_W] = hit_data[p];
      end
      stall_p[p] = hit_p[p] & pend_p[p];
    end
  end

  // A flushed or empty ID slot never stalls.
  assign o_stall = i_id_valid & ~i_flush & (|stall_p);

  // Only real register writes that actually leave ID enter the scoreboard.
  assign issue = i_id_valid & i_id_we & (i_id_rd != '0) & ~o_stall & ~i_flush;

  // Next entry state: new entry or bubble at EX, older entries shift with saturating latency countdown.
  always_comb begin
    valid_d[0] = issue;
    rd_d[0]    = issue ? i_id_rd  : '0;
    rem_d[0]   = issue ? i_id_lat : '0;
    for (int k = 1; k < STAGES; k++) begin
      valid_d[k] = valid_q[k-1];
      rd_d[k]    = rd_q[k-1];
      rem_d[k]   = (rem_q[k-1] == '0) ? '0 : rem_q[k-1] - LAT_W'(1);
    end
  end

  // Scoreboard registers; reset empties every stage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k]  <= '0;
        rem_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < STAGES; k++) begin
        rd_q[k]  <= rd_d[k];
        rem_q[k] <= rem_d[k];
      end
    end
  end

`ifdef ID_FWD_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Stall-cycle counter, saturating at all ones.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (o_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_forward_scoreboard.sv
// tb/tb_id_forward_scoreboard.sv - directed-vector bench for id_forward_scoreboard
module tb_id_forward_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic        id_we;
  logic [4:0]  id_rd;
  logic [1:0]  id_lat;
  logic        flush;
  logic [9:0]  rs;
  logic [63:0] rf_data;
  logic [95:0] stage_data;
  logic [3:0]  fwd_sel;
  logic [63:0] src_data;
  logic        stall;
`ifdef ID_FWD_PERF_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int n_checks;
  int n_fail;

  localparam logic [31:0] RF0 = 32'hF0F0_0000;
  localparam logic [31:0] RF1 = 32'hF1F1_0001;
  localparam logic [31:0] SD0 = 32'hAAAA_0000;
  localparam logic [31:0] SD1 = 32'hBBBB_0001;
  localparam logic [31:0] SD2 = 32'hCCCC_0002;

  id_forward_scoreboard dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_id_valid   (id_valid),
    .i_id_we      (id_we),
    .i_id_rd      (id_rd),
    .i_id_lat     (id_lat),
    .i_flush      (flush),
    .i_rs         (rs),
    .i_rf_data    (rf_data),
    .i_stage_data (stage_data),
    .o_fwd_sel    (fwd_sel),
    .o_src_data   (src_data),
    .o_stall      (stall)
`ifdef ID_FWD_PERF_CNT_EN
    ,
    .o_stall_cnt  (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic v, input logic we, input logic [4:0] rd, input logic [1:0] lat,
                        input logic fl, input logic [4:0] r0, input logic [4:0] r1);
    id_valid = v;
    id_we    = we;
    id_rd    = rd;
    id_lat   = lat;
    flush    = fl;
    rs       = {r1, r0};
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      set_id(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 5'd0);
      tick();
    end
  endtask

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rf_data    = {RF1, RF0};
    stage_data = {SD2, SD1, SD0};
    rst_n      = 1'b0;
    set_id(1'b0, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd5, 5'd8);
    check("reset_stall", {63'd0, stall}, 64'd0);
    check("reset_sel", {60'd0, fwd_sel}, 64'd0);
    check("reset_src", src_data, {RF1, RF0});
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // ALU back-to-back
    set_id(1'b1, 1'b1, 5'd5, 2'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd5, 5'd0);
    check("alu_sel", {60'd0, fwd_sel}, 64'h1);
    check("alu_src", src_data, {RF1, SD0});
    check("alu_stall", {63'd0, stall}, 64'd0);
    tick();
    idle(3);

    // Load-use: reader also writes r10, which must only issue after the stall clears
    set_id(1'b1, 1'b1, 5'd8, 2'd1, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b1, 5'd10, 2'd0, 1'b0, 5'd0, 5'd8);
    check("ld_stall", {63'd0, stall}, 64'd1);
    check("ld_stall_sel", {60'd0, fwd_sel}, 64'd0);
    tick();
    set_id(1'b1, 1'b1, 5'd10, 2'd0, 1'b0, 5'd0, 5'd8);
    check("ld_after_stall", {63'd0, stall}, 64'd0);
    check("ld_mem_sel", {60'd0, fwd_sel}, 64'h8);
    check("ld_mem_src", src_data, {SD1, RF0});
    tick();
    set_id(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd8, 5'd10);
    check("ld_wb_ex_sel", {60'd0, fwd_sel}, 64'h7);
    check("ld_wb_ex_src", src_data, {SD0, SD2});
    check("ld_no_stall", {63'd0, stall}, 64'd0);
    tick();
    idle(3);

    // Youngest wins, same register on both ports
    set_id(1'b1, 1'b1, 5'd3, 2'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b1, 5'd3, 2'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd3, 5'd3);
    check("young_sel", {60'd0, fwd_sel}, 64'h5);
    check("young_src", src_data, {SD0, SD0});
    tick();
    idle(3);

    // Youngest pending overrides an older ready producer; flush masks the stall and blocks issue
    set_id(1'b1, 1'b1, 5'd4, 2'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b1, 5'd4, 2'd1, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b1, 5'd7, 2'd0, 1'b0, 5'd4, 5'd0);
    check("young_pend_stall", {63'd0, stall}, 64'd1);
    check("young_pend_sel", {60'd0, fwd_sel}, 64'd0);
    set_id(1'b1, 1'b1, 5'd7, 2'd0, 1'b1, 5'd4, 5'd0);
    check("flush_stall", {63'd0, stall}, 64'd0);
    tick();
    set_id(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd4, 5'd7);
    check("flush_no_issue_sel", {60'd0, fwd_sel}, 64'h2);
    check("flush_no_issue_src", src_data, {RF1, SD1});
    tick();
    idle(3);

    // r0 is never tracked
    set_id(1'b1, 1'b1, 5'd0, 2'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 5'd0);
    check("r0_sel", {60'd0, fwd_sel}, 64'd0);
    check("r0_src", src_data, {RF1, RF0});
    check("r0_stall", {63'd0, stall}, 64'd0);
    tick();
    idle(3);

    // Producer walks EX -> MEM -> WB -> retired
    set_id(1'b1, 1'b1, 5'd9, 2'd0, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd9, 5'd0);
    check("walk_ex", {60'd0, fwd_sel}, 64'h1);
    tick();
    check("walk_mem", {60'd0, fwd_sel}, 64'h2);
    tick();
    check("walk_wb", {60'd0, fwd_sel}, 64'h3);
    check("walk_wb_src", src_data, {RF1, SD2});
    tick();
    check("retire_sel", {60'd0, fwd_sel}, 64'd0);
    check("retire_src", src_data, {RF1, RF0});
    tick();
    idle(3);

    // Latency beyond the tracked depth: stalls while tracked, then regfile path
    set_id(1'b1, 1'b1, 5'd11, 2'd3, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd11, 5'd0);
    check("longlat_stall0", {63'd0, stall}, 64'd1);
    tick();
    check("longlat_stall1", {63'd0, stall}, 64'd1);
    tick();
    check("longlat_stall2", {63'd0, stall}, 64'd1);
    tick();
    check("longlat_retired_stall", {63'd0, stall}, 64'd0);
    check("longlat_retired_src", src_data, {RF1, RF0});
    tick();
    idle(3);

    // Reset while a load-use stall is pending
    set_id(1'b1, 1'b1, 5'd8, 2'd1, 1'b0, 5'd0, 5'd0);
    tick();
    set_id(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 5'd8);
    check("rst_pre_stall", {63'd0, stall}, 64'd1);
`ifdef ID_FWD_PERF_CNT_EN
    check("cnt_before_rst", {32'd0, stall_cnt}, 64'd4);
`endif
    rst_n = 1'b0;
    #1;
    check("rst_mid_stall", {63'd0, stall}, 64'd0);
    check("rst_mid_sel", {60'd0, fwd_sel}, 64'd0);
`ifdef ID_FWD_PERF_CNT_EN
    check("cnt_after_rst", {32'd0, stall_cnt}, 64'd0);
`endif
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    set_id(1'b1, 1'b0, 5'd0, 2'd0, 1'b0, 5'd0, 5'd8);
    check("post_rst_stall", {63'd0, stall}, 64'd0);
    check("post_rst_src", src_data, {RF1, RF0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
